// File: rtl/loadable_program_memory.sv
// Program memory whose contents are written at runtime through a valid/ready loader port.
// Fetches are served with one-cycle latency; anything outside the loaded program reads as NOP.
module loadable_program_memory #(
  parameter int ADDRESS_WIDTH          = 5,
  parameter int INSTRUCTION_WIDTH      = 16,
  parameter int NUMBER_OF_INSTRUCTIONS = 32,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION = 16'h000F
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_start,
  input  logic                         load_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] load_data,
  input  logic                         load_last,
  output logic                         load_ready,
  input  logic                         fetch_enable,
  input  logic [ADDRESS_WIDTH-1:0]     instruction_address,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         instruction_valid,
  output logic [ADDRESS_WIDTH:0]       program_length,
  output logic                         loaded,
  output logic                         load_error
);

  typedef enum logic [1:0] {IDLE, LOADING, RUN} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_PTR = ADDRESS_WIDTH'(NUMBER_OF_INSTRUCTIONS - 1);
  localparam logic [ADDRESS_WIDTH:0]   DEPTH    = (ADDRESS_WIDTH + 1)'(NUMBER_OF_INSTRUCTIONS);

  state_t state, state_next;

  logic [INSTRUCTION_WIDTH-1:0] mem [NUMBER_OF_INSTRUCTIONS];
  logic [ADDRESS_WIDTH-1:0]     wr_ptr;
  logic                         beat_accept;
  logic                         fetch_hit;
  logic [ADDRESS_WIDTH:0]       fetch_addr_ext;
  logic [INSTRUCTION_WIDTH-1:0] fetch_word;

  assign beat_accept = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, RUN: begin
        if (load_start) state_next = LOADING;
      end
      LOADING: begin
        if (load_start)
          state_next = LOADING;
        else if (beat_accept && (load_last || wr_ptr == LAST_PTR))
          state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state == LOADING) && !load_start;
    loaded     = (state == RUN);
  end

  // load_start restarts the session from any state, taking priority over a same-cycle beat.
  always_ff @(posedge clk) begin
    if (rst || load_start) begin
      wr_ptr         <= '0;
      program_length <= '0;
      load_error     <= 1'b0;
    end else begin
      if (beat_accept) begin
        if (wr_ptr != LAST_PTR) wr_ptr <= wr_ptr + ADDRESS_WIDTH'(1);
        if (program_length < DEPTH)
          program_length <= program_length + (ADDRESS_WIDTH + 1)'(1);
      end
      if (load_valid && state != LOADING) load_error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_accept) mem[wr_ptr] <= load_data;
  end

  always_comb begin
    fetch_addr_ext = {1'b0, instruction_address};
    fetch_hit      = (state == RUN) && (fetch_addr_ext < program_length)
                     && (fetch_addr_ext < DEPTH);
    fetch_word     = fetch_hit ? mem[instruction_address] : NOP_INSTRUCTION;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instruction       <= NOP_INSTRUCTION;
      instruction_valid <= 1'b0;
    end else begin
      instruction_valid <= fetch_enable;
      if (fetch_enable) instruction <= fetch_word;
    end
  end

endmodule

// File: tb/tb_loadable_program_memory.sv
// Directed bench for loadable_program_memory: load sessions, restarts, resets and fetch responses.
module tb_loadable_program_memory;

  logic        clk;
  logic        rst;
  logic        load_start;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        fetch_enable;
  logic [4:0]  instruction_address;
  logic [15:0] instruction;
  logic        instruction_valid;
  logic [5:0]  program_length;
  logic        loaded;
  logic        load_error;

  int unsigned vectors;
  int unsigned miscompares;

  loadable_program_memory #(
    .ADDRESS_WIDTH(5),
    .INSTRUCTION_WIDTH(16),
    .NUMBER_OF_INSTRUCTIONS(32),
    .NOP_INSTRUCTION(16'h000F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_last(load_last),
    .load_ready(load_ready),
    .fetch_enable(fetch_enable),
    .instruction_address(instruction_address),
    .instruction(instruction),
    .instruction_valid(instruction_valid),
    .program_length(program_length),
    .loaded(loaded),
    .load_error(load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat, checks the combinational ready, then clocks it in.
  task automatic beat(input logic [15:0] data, input logic last, input logic exp_ready);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    #1;
    check("load_ready_beat", load_ready, exp_ready);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic fetch(input logic [4:0] addr, input logic [15:0] exp, input string tag);
    fetch_enable        = 1'b1;
    instruction_address = addr;
    tick();
    fetch_enable = 1'b0;
    check(tag, instruction, exp);
    check("fetch_valid", instruction_valid, 1'b1);
  endtask

  initial begin
    logic [15:0] short_prog [4];
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    fetch_enable = 1'b0; instruction_address = '0;
    tick();
    tick();
    rst = 1'b0;

    check("reset_instruction", instruction, 16'h000F);
    check("reset_valid", instruction_valid, 1'b0);
    check("reset_length", program_length, 6'd0);
    check("reset_loaded", loaded, 1'b0);
    check("reset_error", load_error, 1'b0);
    check("reset_ready", load_ready, 1'b0);
    fetch(5'd0, 16'h000F, "reset_fetch0");
    tick();
    check("valid_drops", instruction_valid, 1'b0);

    // Short load of three words, then back-to-back fetches including one past the end.
    start_load();
    beat(16'h0000, 1'b0, 1'b1);
    beat(16'h0007, 1'b0, 1'b1);
    check("short_not_loaded_yet", loaded, 1'b0);
    beat(16'h0026, 1'b1, 1'b1);
    check("short_loaded", loaded, 1'b1);
    check("short_length", program_length, 6'd3);
    short_prog[0] = 16'h0000; short_prog[1] = 16'h0007;
    short_prog[2] = 16'h0026; short_prog[3] = 16'h000F;
    fetch_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instruction_address = 5'(i);
      tick();
      check("short_fetch", instruction, short_prog[i]);
      check("short_valid", instruction_valid, 1'b1);
    end
    fetch_enable = 1'b0;
    tick();
    check("hold_instruction", instruction, 16'h000F);
    check("hold_valid", instruction_valid, 1'b0);

    // Full memory ends the session without load_last.
    start_load();
    check("restart_length", program_length, 6'd0);
    check("restart_loaded", loaded, 1'b0);
    for (int i = 0; i < 32; i++) beat(16'(i << 4), 1'b0, 1'b1);
    check("full_loaded", loaded, 1'b1);
    check("full_length", program_length, 6'd32);
    check("full_error_clear", load_error, 1'b0);
    load_valid = 1'b1; load_data = 16'hDEAD;
    #1;
    check("run_ready", load_ready, 1'b0);
    tick();
    load_valid = 1'b0;
    check("run_beat_error", load_error, 1'b1);
    check("run_beat_length", program_length, 6'd32);
    fetch(5'd31, 16'h01F0, "full_fetch31");
    fetch(5'd5, 16'h0050, "full_fetch5");

    // Restart mid-load: the beat in the restart cycle is dropped.
    start_load();
    check("restart_clears_error", load_error, 1'b0);
    for (int i = 0; i < 5; i++) beat(16'hA000 + 16'(i), 1'b0, 1'b1);
    check("midload_length5", program_length, 6'd5);
    load_start = 1'b1;
    beat(16'hBEEF, 1'b0, 1'b0);
    load_start = 1'b0;
    check("restart_length_zero", program_length, 6'd0);
    check("restart_no_error", load_error, 1'b0);
    beat(16'h1111, 1'b0, 1'b1);
    beat(16'h2222, 1'b1, 1'b1);
    check("restart_loaded", loaded, 1'b1);
    check("restart_length2", program_length, 6'd2);
    fetch(5'd0, 16'h1111, "restart_fetch0");
    fetch(5'd1, 16'h2222, "restart_fetch1");
    fetch(5'd4, 16'h000F, "restart_fetch4_nop");

    // Reset during the third beat abandons the session.
    start_load();
    beat(16'h3000, 1'b0, 1'b1);
    beat(16'h3001, 1'b0, 1'b1);
    rst = 1'b1;
    beat(16'h3002, 1'b0, 1'b1);
    rst = 1'b0;
    check("rst_mid_length", program_length, 6'd0);
    check("rst_mid_loaded", loaded, 1'b0);
    check("rst_mid_ready", load_ready, 1'b0);
    check("rst_mid_error", load_error, 1'b0);
    fetch(5'd0, 16'h000F, "rst_mid_fetch0");

    // Fetches during LOADING, including the final-beat cycle, return NOP.
    start_load();
    fetch_enable = 1'b1;
    instruction_address = 5'd0;
    beat(16'h5555, 1'b0, 1'b1);
    check("loading_fetch_a", instruction, 16'h000F);
    check("loading_valid_a", instruction_valid, 1'b1);
    beat(16'h6666, 1'b0, 1'b1);
    check("loading_fetch_b", instruction, 16'h000F);
    beat(16'h7777, 1'b1, 1'b1);
    check("final_beat_fetch", instruction, 16'h000F);
    check("final_beat_valid", instruction_valid, 1'b1);
    check("final_loaded", loaded, 1'b1);
    fetch_enable = 1'b0;
    tick();
    check("loading_hold", instruction, 16'h000F);
    check("loading_hold_valid", instruction_valid, 1'b0);
    fetch(5'd0, 16'h5555, "first_run_fetch");
    fetch(5'd2, 16'h7777, "last_run_fetch");
    fetch(5'd3, 16'h000F, "past_end_fetch");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
